// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter.
// Widths, FSM state encoding and requester ids.
package dmem_arbiter_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GNT_CPU = 2'd1,
    GNT_DBG = 2'd2
  } state_t;

  localparam logic CPU = 1'b0;
  localparam logic DBG = 1'b1;

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-way round-robin picker, purely combinational.
// Excluded requesters are masked before the pick.
module rr_arb2
  import dmem_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_owner,
  input  logic [1:0] exclude,
  output logic       grant,
  output logic       valid
);

  logic [1:0] elig;

  assign elig = req & ~exclude;

  // Single eligible wins; a tie goes away from last_owner.
  always_comb begin
    valid = |elig;
    grant = CPU;
    case (elig)
      2'b01:   grant = CPU;
      2'b10:   grant = DBG;
      2'b11:   grant = ~last_owner;
      default: grant = CPU;
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter between the CPU and the debug/loader port.
// One access per grant cycle; reads return one cycle later.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_gnt,
  output logic              dbg_rvalid,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [DATA_W-1:0] mem_rdata
);

  state_t     state;
  state_t     state_nx;
  logic       last_owner;
  logic [1:0] req;
  logic [1:0] excl;
  logic       pick;
  logic       pick_ok;

  assign req  = {dbg_req, cpu_req};
  // The current owner may not be granted twice in a row.
  assign excl = {state == GNT_DBG, state == GNT_CPU};

  rr_arb2 u_arb (
    .req        (req),
    .last_owner (last_owner),
    .exclude    (excl),
    .grant      (pick),
    .valid      (pick_ok)
  );

  assign cpu_gnt = (state == GNT_CPU);
  assign dbg_gnt = (state == GNT_DBG);

  // Next grant straight from the picker.
  always_comb begin
    state_nx = IDLE;
    if (pick_ok)
      state_nx = (pick == DBG) ? GNT_DBG : GNT_CPU;
  end

  // Route the granted port to memory; idle drives zeros.
  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    if (cpu_gnt) begin
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
      mem_we    = cpu_we;
      mem_re    = ~cpu_we;
    end else if (dbg_gnt) begin
      mem_addr  = dbg_addr;
      mem_wdata = dbg_wdata;
      mem_we    = dbg_we;
      mem_re    = ~dbg_we;
    end
  end

  // Grant state and round-robin history.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      last_owner <= DBG;
    end else begin
      state <= state_nx;
      if (pick_ok)
        last_owner <= pick;
    end
  end

  // Capture read data at the grant edge; reset drops it.
  always_ff @(posedge clk) begin
    if (reset) begin
      cpu_rvalid <= 1'b0;
      dbg_rvalid <= 1'b0;
      cpu_rdata  <= '0;
      dbg_rdata  <= '0;
    end else begin
      cpu_rvalid <= cpu_gnt & ~cpu_we;
      dbg_rvalid <= dbg_gnt & ~dbg_we;
      if (cpu_gnt & ~cpu_we)
        cpu_rdata <= mem_rdata;
      if (dbg_gnt & ~dbg_we)
        dbg_rdata <= mem_rdata;
    end
  end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameters: ADDR_W, 8, data-memory address width.
REQ-002 Parameters: DATA_W, 8, data-memory word width.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 cpu_req  input  1  processor requests one data-memory access.
REQ-006 cpu_we  input  1  1 = write, 0 = read; valid while cpu_req.
REQ-007 cpu_addr  input  ADDR_W  processor access address.
REQ-008 cpu_wdata  input  DATA_W  processor write data.
REQ-009 cpu_gnt  output  1  processor access performed this cycle.
REQ-010 cpu_rvalid  output  1  cpu_rdata holds read result.
REQ-011 cpu_rdata  output  DATA_W  processor read data.
REQ-012 dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_gnt, dbg_rvalid, dbg_rdata: debug/loader port; same directions, widths and meanings as the cpu_* ports.
REQ-013 mem_addr  output  ADDR_W  address to data memory.
REQ-014 mem_wdata  output  DATA_W  write data to data memory.
REQ-015 mem_we  output  1  data-memory write strobe.
REQ-016 mem_re  output  1  data-memory read strobe.
REQ-017 mem_rdata  input  DATA_W  combinational read data from data memory.

Function
REQ-018 FSM states: IDLE, GNT_CPU, GNT_DBG; the state register directly drives cpu_gnt (GNT_CPU) and dbg_gnt (GNT_DBG); at most one gnt is high per cycle.
REQ-019 Requester holds req, we, addr and wdata stable from req assertion through its gnt cycle; exactly one access per gnt pulse.
REQ-020 Next-state decision at each edge uses req sampled that cycle; the requester owning the current grant is excluded, so no requester is granted two consecutive cycles.
REQ-021 Only one eligible requester: grant it. Both eligible: grant the one not in last_owner. None: IDLE.
REQ-022 last_owner updates to the granted port on every entry into GNT_CPU or GNT_DBG.
REQ-023 Latency: req seen in IDLE -> gnt next cycle; back-to-back alternation CPU/DBG at one grant per cycle is supported.
REQ-024 In a gnt cycle, mem_addr/mem_wdata follow the granted port, mem_we = granted we, mem_re = not granted we; outside a gnt cycle mem_we = mem_re = 0 and mem_addr/mem_wdata = 0.
REQ-025 Read: mem_rdata is registered at the gnt edge; the granted port's rvalid is high for exactly the following cycle with rdata = that value; the other port's rvalid stays 0.
REQ-026 rdata of each port holds its last read value until the next read on that port.
REQ-027 Writes never raise rvalid.
REQ-028 A req deasserted before gnt is dropped without a memory access.

Reset
REQ-029 On reset at a clock edge: state = IDLE, cpu_gnt = dbg_gnt = 0, cpu_rvalid = dbg_rvalid = 0, cpu_rdata = dbg_rdata = 0, last_owner = DBG (CPU wins the first tie).
REQ-030 Reset asserted in a gnt cycle: the access in that cycle completes at the memory, but its rvalid is suppressed.
REQ-031 Reset has priority over all requests; the first grant is possible the cycle after reset deasserts.

Structure
REQ-032 The shared package holds the ADDR_W/DATA_W defaults, the state enum (IDLE, GNT_CPU, GNT_DBG) and the port-id constants CPU = 0 and DBG = 1.
REQ-033 One sub-module, rr_arb2: a combinational 2-way round-robin picker (inputs req[1:0], last_owner, exclude; outputs grant id and valid).

Verification
REQ-034 CPU read only: preload mem[0x10] = 0xA5; cpu_req=1, we=0, addr=0x10 -> cpu_gnt at cycle 1, cpu_rvalid at cycle 2 with cpu_rdata = 0xA5, mem_re high only in cycle 1.
REQ-035 Simultaneous requests after reset: both req held -> grants CPU, DBG, CPU, DBG on consecutive cycles, never the same port twice in a row.
REQ-036 DBG write 0x3C to 0x20, then CPU read 0x20 -> mem_we pulses once with addr 0x20, data 0x3C; cpu_rdata = 0x3C; dbg_rvalid stays 0.
REQ-037 Single requester holding req continuously -> gnt every other cycle (1,0,1,0).
REQ-038 Reset asserted during a CPU read gnt cycle -> cpu_rvalid = 0 next cycle; all outputs 0; the next tie is granted to CPU.
REQ-039 cpu_req dropped before gnt while dbg_req is idle -> no mem_we/mem_re pulse and FSM remains IDLE.
